reset_sequencer: RTL
====================

// Module: reset_sequencer
//
// PURPOSE
// Multi-channel reset controller: asserts NUM_CH reset outputs together and releases them
//   in index order, RELEASE_GAP enabled cycles apart.
// Release waits for a minimum assertion time and a debounced PLL-lock indication.
// Sits at the top level and drives the resets of the video pipeline, scaler and
//   config/CPU domains (all derived from clk).
// Also supports a software reset request and re-sequences on PLL lock loss.
//
// PARAMETERS
// NUM_CH       3     number of reset outputs (>=1)
// ACTIVE_STATE 1'b0  asserted level of rst_o bits
// RST_LENGTH   2     minimum assertion, in clk_en cycles (>=1)
// LOCK_FILTER  8     consecutive enabled cycles of synced lock required (>=1)
// RELEASE_GAP  4     enabled cycles between release of ch k and ch k+1 (>=1)
//
// PORTS
// clk           in   1       clock
// async_nrst_i  in   1       reset, asynchronous, active-low
// clk_en        in   1       count enable; counters advance only when high
// pll_locked_i  in   1       PLL lock, asynchronous to clk
// sw_rst_req_i  in   1       software reset request, level, sync to clk
// rst_o         out  NUM_CH  per-channel reset, ACTIVE_STATE = asserted
// done_o        out  1       high when all channels released (state RUN)
//
// BEHAVIOUR
// - async_nrst_i low, or power-up init:
//   - all rst_o = ACTIVE_STATE, done_o = 0, state HOLD.
//   - All counters and the synchronizer are 0.
//   - Assertion is immediate (async); release is always synchronous.
// - pll_locked_i passes a 2-FF synchronizer (lock_s).
// - lock_cnt:
//   - increments on clk_en cycles while lock_s = 1, saturating at LOCK_FILTER.
//   - cleared on any clk edge with lock_s = 0 (clk_en ignored).
//   - lock_ok = (lock_cnt == LOCK_FILTER).
// - States HOLD -> RELEASE -> RUN.
// - HOLD:
//   - all rst_o asserted.
//   - hold_cnt counts clk_en cycles up to RST_LENGTH, saturating.
//   - Exit when hold_cnt == RST_LENGTH && lock_ok && !sw_rst_req_i.
//   - On the exit edge: rst_o[0] released, gap_cnt = 0, ch_idx = 1.
//   - If NUM_CH == 1, go directly to RUN.
// - RELEASE:
//   - gap_cnt increments on clk_en.
//   - When gap_cnt reaches RELEASE_GAP: release rst_o[ch_idx], gap_cnt = 0, ch_idx++.
//   - The edge releasing ch NUM_CH-1 enters RUN and sets done_o = 1.
// - RUN: steady state; outputs are held.
// - Re-assertion (from RELEASE or RUN, on any clk edge, clk_en ignored):
//   - trigger is sw_rst_req_i = 1 or lock_s = 0.
//   - next edge: all rst_o asserted, done_o = 0, state HOLD, hold_cnt = 0.
//   - While sw_rst_req_i stays high, hold_cnt is held at 0, so RST_LENGTH counts from its falling edge.
// - Simultaneous exit condition and trigger in HOLD: the trigger wins; stay in HOLD.
// - Released channels never re-assert individually. Assertion is always all-channel.
// - rst_o is only ever a prefix release: bits 0..k released, the rest asserted.
// - Counter widths: $clog2(max(RST_LENGTH, LOCK_FILTER, RELEASE_GAP) + 1); ch_idx width $clog2(NUM_CH + 1).
// - clk_en low freezes all counters and release progress; it does not block re-assertion.
//
// STRUCTURE
// - No shared package is needed. The state encoding is local to this module (localparams).
// - One sub-module: sync_2ff.
//   - 2-stage synchronizer, async-cleared to 0 by async_nrst_i.
//   - Reusable for other async status inputs.
// - Remainder is one FSM plus three counters, all in this module.
//
// TESTING
// Defaults, clk_en = 1, lock high before reset release; edge 1 = first clk after async_nrst_i rises.
// 1. Basic sequencing -> lock_ok after edge 10; rst_o[0] released at edge 11, [1] at 15, [2] at 19;
//    done_o = 1 at 19.
// 2. Lock glitch: lock low for 1 cycle at edge 16 (synced) -> all rst_o asserted at edge 17, done_o = 0;
//    full re-sequence with a fresh 8-cycle filter.
// 3. sw_rst_req_i high for 5 cycles in RUN -> assertion on the next edge;
//    release of ch0 exactly RST_LENGTH = 2 cycles after the request falls (lock stable).
// 4. clk_en = 1 every 3rd cycle -> all release gaps = 12 clk;
//    lock loss with clk_en = 0 still asserts all rst_o within 1 clk.
// 5. async_nrst_i pulsed low mid-RELEASE (asynchronous to clk) -> rst_o asserted without waiting for a
//    clk edge; lock_cnt = 0; restart as in test 1.
// 6. Parameter sweep NUM_CH = 1 / ACTIVE_STATE = 1, RST_LENGTH = 1 -> single bit, active-high polarity
//    correct; done_o coincides with rst_o[0] release.

Source files
------------

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for asynchronous status inputs.
// Both stages clear to 0 while async_nrst_i is low.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             async_nrst_i,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge async_nrst_i) begin
    if (!async_nrst_i) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-channel reset controller: asserts all channels together and releases them in index
// order once the minimum hold time has elapsed and the PLL lock has been stable long enough.
module reset_sequencer #(
  parameter int   NUM_CH       = 3,
  parameter logic ACTIVE_STATE = 1'b0,
  parameter int   RST_LENGTH   = 2,
  parameter int   LOCK_FILTER  = 8,
  parameter int   RELEASE_GAP  = 4
) (
  input  logic              clk,
  input  logic              async_nrst_i,
  input  logic              clk_en,
  input  logic              pll_locked_i,
  input  logic              sw_rst_req_i,
  output logic [NUM_CH-1:0] rst_o,
  output logic              done_o
);

  localparam int MAX_AB  = (RST_LENGTH > LOCK_FILTER) ? RST_LENGTH : LOCK_FILTER;
  localparam int MAX_CNT = (MAX_AB > RELEASE_GAP) ? MAX_AB : RELEASE_GAP;
  localparam int CW      = $clog2(MAX_CNT + 1);
  localparam int IW      = $clog2(NUM_CH + 1);

  localparam logic [CW-1:0] HOLD_LEN = CW'(RST_LENGTH);
  localparam logic [CW-1:0] LOCK_LEN = CW'(LOCK_FILTER);
  localparam logic [CW-1:0] GAP_LAST = CW'(RELEASE_GAP - 1);
  localparam logic [IW-1:0] LAST_CH  = IW'(NUM_CH - 1);

  localparam logic [1:0] ST_HOLD    = 2'd0;
  localparam logic [1:0] ST_RELEASE = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  logic [1:0]        state;
  logic [CW-1:0]     hold_cnt;
  logic [CW-1:0]     gap_cnt;
  logic [CW-1:0]     lock_cnt;
  logic [IW-1:0]     ch_idx;
  logic [NUM_CH-1:0] rst_q;
  logic              done_q;
  logic              lock_s;
  logic              lock_ok;
  logic              trigger;

  sync_2ff #(
    .WIDTH(1)
  ) u_lock_sync (
    .clk          (clk),
    .async_nrst_i (async_nrst_i),
    .d            (pll_locked_i),
    .q            (lock_s)
  );

  // A single low sample of the synced lock restarts the filter, even with clk_en low.
  always_ff @(posedge clk or negedge async_nrst_i) begin
    if (!async_nrst_i) begin
      lock_cnt <= '0;
    end else if (!lock_s) begin
      lock_cnt <= '0;
    end else if (clk_en && (lock_cnt != LOCK_LEN)) begin
      lock_cnt <= lock_cnt + 1'b1;
    end
  end

  assign lock_ok = (lock_cnt == LOCK_LEN);
  assign trigger = sw_rst_req_i || !lock_s;

  // rst_q is registered so outputs only ever move as a clean prefix release;
  // assertion is all-channel and ignores clk_en.
  always_ff @(posedge clk or negedge async_nrst_i) begin
    if (!async_nrst_i) begin
      state    <= ST_HOLD;
      hold_cnt <= '0;
      gap_cnt  <= '0;
      ch_idx   <= '0;
      rst_q    <= {NUM_CH{ACTIVE_STATE}};
      done_q   <= 1'b0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (sw_rst_req_i) begin
            hold_cnt <= '0;
          end else if (clk_en && (hold_cnt != HOLD_LEN)) begin
            hold_cnt <= hold_cnt + 1'b1;
          end
          if (!trigger && clk_en && lock_ok && (hold_cnt == HOLD_LEN)) begin
            rst_q[0] <= ~ACTIVE_STATE;
            gap_cnt  <= '0;
            ch_idx   <= IW'(1);
            if (NUM_CH == 1) begin
              state  <= ST_RUN;
              done_q <= 1'b1;
            end else begin
              state  <= ST_RELEASE;
            end
          end
        end
        ST_RELEASE: begin
          if (trigger) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            ch_idx   <= '0;
            rst_q    <= {NUM_CH{ACTIVE_STATE}};
            done_q   <= 1'b0;
          end else if (clk_en) begin
            if (gap_cnt == GAP_LAST) begin
              gap_cnt <= '0;
              ch_idx  <= ch_idx + 1'b1;
              for (int i = 0; i < NUM_CH; i++) begin
                if (ch_idx == IW'(i)) begin
                  rst_q[i] <= ~ACTIVE_STATE;
                end
              end
              if (ch_idx == LAST_CH) begin
                state  <= ST_RUN;
                done_q <= 1'b1;
              end
            end else begin
              gap_cnt <= gap_cnt + 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (trigger) begin
            state    <= ST_HOLD;
            hold_cnt <= '0;
            gap_cnt  <= '0;
            ch_idx   <= '0;
            rst_q    <= {NUM_CH{ACTIVE_STATE}};
            done_q   <= 1'b0;
          end
        end
        default: begin
          state    <= ST_HOLD;
          hold_cnt <= '0;
          gap_cnt  <= '0;
          ch_idx   <= '0;
          rst_q    <= {NUM_CH{ACTIVE_STATE}};
          done_q   <= 1'b0;
        end
      endcase
    end
  end

  assign rst_o  = rst_q;
  assign done_o = done_q;

endmodule
